spi_target: RTL and testbench

- SPI mode-0 slave (target) that turns SCK/SS/SI/SO pin activity into the team's byte valid/ready streams.
- It is the far end of the byte-stream SPI master used by the bootloader, so the team can model, exercise and bridge that link inside the FPGA.
- All SPI pins are oversampled in the clk domain. There is no logic clocked by SCK.

---
 rtl/spi_target.sv | 174 +++++++++++++++++
 tb/tb_spi_target.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target: pins are oversampled in the clk domain and bridged to byte
// valid/ready streams, with a one-entry TX holding register and sticky error flags.
module spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_spi_sck,
    input  logic       i_spi_ss,
    input  logic       i_spi_si,
    output logic       o_spi_so,
    output logic       o_spi_so_oe,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_first,
    input  logic       i_rx_ready,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_frame_start,
    output logic       o_frame_end,
    output logic       o_rx_overflow,
    output logic       o_tx_underrun
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_si_sync;
    logic                   r_sck_d;
    logic                   r_ss_d;
    logic [2:0]             r_bit_cnt;
    logic                   r_first;
    logic [7:0]             r_hold;
    logic [6:0]             r_tx_shift;
    logic [6:0]             r_rx_shift;

    logic       w_sck;
    logic       w_ss;
    logic       w_si;
    logic       w_ss_rise;
    logic       w_ss_fall;
    logic       w_start;
    logic       w_end;
    logic       w_sck_rise_act;
    logic       w_sck_fall_act;
    logic       w_tx_load;
    logic       w_rx_done;
    logic       w_hold_wr;
    logic [7:0] w_load_byte;
    logic [7:0] w_rx_byte;

    assign w_sck = r_sck_sync[SYNC_STAGES-1];
    assign w_ss  = r_ss_sync[SYNC_STAGES-1];
    assign w_si  = r_si_sync[SYNC_STAGES-1];

    assign w_ss_rise      = w_ss & ~r_ss_d;
    assign w_ss_fall      = ~w_ss & r_ss_d;
    assign w_start        = (r_state == IDLE) && w_ss_fall;
    assign w_end          = (r_state == ACTIVE) && w_ss_rise;
    // A deselect in the same cycle as an SCK edge wins over the edge.
    assign w_sck_rise_act = (r_state == ACTIVE) && !w_ss_rise && w_sck && !r_sck_d;
    assign w_sck_fall_act = (r_state == ACTIVE) && !w_ss_rise && !w_sck && r_sck_d;
    assign w_tx_load      = w_start || (w_sck_fall_act && (r_bit_cnt == 3'd0));
    assign w_rx_done      = w_sck_rise_act && (r_bit_cnt == 3'd7);
    assign w_hold_wr      = i_tx_valid && o_tx_ready;
    assign w_load_byte    = o_tx_ready ? FILL_BYTE : r_hold;
    assign w_rx_byte      = {r_rx_shift, w_si};

    // Synchronised ss resets low so a master already mid-frame is never joined.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sck_sync <= '0;
            r_ss_sync  <= '0;
            r_sck_d    <= 1'b0;
            r_ss_d     <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
            r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], i_spi_ss};
            r_sck_d    <= w_sck;
            r_ss_d     <= w_ss;
        end
    end

    always_ff @(posedge i_clk) begin
        r_si_sync <= {r_si_sync[SYNC_STAGES-2:0], i_spi_si};
        if (w_hold_wr)
            r_hold <= i_tx_data;
        if (w_tx_load)
            r_tx_shift <= w_load_byte[6:0];
        else if (w_sck_fall_act)
            r_tx_shift <= {r_tx_shift[5:0], 1'b0};
        if (w_sck_rise_act)
            r_rx_shift <= w_rx_byte[6:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= WAIT_IDLE;
            o_spi_so      <= 1'b1;
            o_spi_so_oe   <= 1'b0;
            o_rx_valid    <= 1'b0;
            o_rx_data     <= 8'h00;
            o_rx_first    <= 1'b0;
            o_tx_ready    <= 1'b1;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_rx_overflow <= 1'b0;
            o_tx_underrun <= 1'b0;
            r_bit_cnt     <= 3'd0;
            r_first       <= 1'b0;
        end else begin
            o_frame_start <= w_start;
            o_frame_end   <= w_end;

            // A write into an empty register and a load in the same cycle leaves it full.
            if (w_hold_wr)
                o_tx_ready <= 1'b0;
            else if (w_tx_load)
                o_tx_ready <= 1'b1;
            if (w_tx_load && o_tx_ready)
                o_tx_underrun <= 1'b1;

            if (w_rx_done) begin
                if (o_rx_valid && !i_rx_ready) begin
                    o_rx_overflow <= 1'b1;
                end else begin
                    o_rx_valid <= 1'b1;
                    o_rx_data  <= w_rx_byte;
                    o_rx_first <= r_first;
                end
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end

            case (r_state)
                WAIT_IDLE: begin
                    if (w_ss)
                        r_state <= IDLE;
                end
                IDLE: begin
                    if (w_ss_fall) begin
                        o_spi_so_oe <= 1'b1;
                        o_spi_so    <= w_load_byte[7];
                        r_bit_cnt   <= 3'd0;
                        r_first     <= 1'b1;
                        r_state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_ss_rise) begin
                        o_spi_so_oe <= 1'b0;
                        o_spi_so    <= 1'b1;
                        r_bit_cnt   <= 3'd0;
                        r_state     <= IDLE;
                    end else begin
                        if (w_sck_rise_act) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7)
                                r_first <= 1'b0;
                        end
                        if (w_sck_fall_act)
                            o_spi_so <= (r_bit_cnt == 3'd0) ? w_load_byte[7] : r_tx_shift[6];
                    end
                end
                default: r_state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a bit-banged mode-0 master with a byte-level
// model of the holding register, RX delivery and sticky flags.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       si = 1'b0;
    logic       rx_ready = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       so, so_oe, rx_valid, rx_first, tx_ready;
    logic       frame_start, frame_end, rx_overflow, tx_underrun;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    spi_target dut (
        .i_clk(clk), .i_reset(reset), .i_spi_sck(sck), .i_spi_ss(ss), .i_spi_si(si),
        .o_spi_so(so), .o_spi_so_oe(so_oe), .o_rx_valid(rx_valid), .o_rx_data(rx_data),
        .o_rx_first(rx_first), .i_rx_ready(rx_ready), .i_tx_valid(tx_valid),
        .i_tx_data(tx_data), .o_tx_ready(tx_ready), .o_frame_start(frame_start),
        .o_frame_end(frame_end), .o_rx_overflow(rx_overflow), .o_tx_underrun(tx_underrun)
    );

    int checks = 0;
    int failures = 0;

    logic [8:0] q_rx[$];
    logic [7:0] q_miso[$];

    logic       m_hold_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic       m_und = 1'b0;
    logic       m_ovf = 1'b0;
    logic       stalled = 1'b0;
    int         m_stall_held = 0;
    int         exp_fs = 0, exp_fe = 0, cnt_fs = 0, cnt_fe = 0;
    logic       mon_en = 1'b1;

    logic [7:0] mosi_b [4];
    logic       sup_v  [4];
    logic [7:0] sup_b  [4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] model_load();
        if (m_hold_full) begin
            m_hold_full = 1'b0;
            return m_hold;
        end
        m_und = 1'b1;
        return 8'hFF;
    endfunction

    task automatic model_rx(input logic [7:0] b, input logic first);
        if (stalled && m_stall_held > 0)
            m_ovf = 1'b1;
        else
            q_rx.push_back({first, b});
        if (stalled)
            m_stall_held++;
    endtask

    // Frame pulses and accepted RX bytes, sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (frame_start) cnt_fs++;
        if (frame_end) cnt_fe++;
        if (rx_valid && rx_ready) begin
            if (q_rx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
            end else begin
                logic [8:0] e;
                e = q_rx.pop_front();
                check("rx_data", rx_data, e[7:0]);
                check("rx_first", rx_first, e[8]);
            end
        end
    end

    // MISO bits as the master sees them on each SCK rising edge.
    logic [7:0] miso_acc = 8'h00;
    int         miso_cnt = 0;
    always @(posedge sck or posedge ss) begin
        if (ss) begin
            miso_cnt = 0;
        end else if (mon_en) begin
            check("so_oe_active", so_oe, 1);
            miso_acc = {miso_acc[6:0], so};
            miso_cnt++;
            if (miso_cnt == 8) begin
                miso_cnt = 0;
                if (q_miso.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL miso_unexpected actual=%0h required=none", miso_acc);
                end else begin
                    check("miso", miso_acc, q_miso.pop_front());
                end
            end
        end
    end

    task automatic offer_tx(input logic [7:0] b);
        check("tx_ready", tx_ready, !m_hold_full);
        if (!m_hold_full) begin
            tx_valid = 1'b1;
            tx_data  = b;
            tick(1);
            tx_valid = 1'b0;
            m_hold      = b;
            m_hold_full = 1'b1;
        end
    endtask

    task automatic check_reset_values();
        check("rst_so", so, 1);
        check("rst_so_oe", so_oe, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_first", rx_first, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_end", frame_end, 0);
        check("rst_rx_overflow", rx_overflow, 0);
        check("rst_tx_underrun", tx_underrun, 0);
    endtask

    task automatic apply_reset();
        int t = 0;
        while (q_rx.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        check("rx_drain_before_reset", q_rx.size(), 0);
        check("miso_drain_before_reset", q_miso.size(), 0);
        reset = 1'b1;
        tick(2);
        check_reset_values();
        reset = 1'b0;
        m_hold_full = 1'b0;
        m_und = 1'b0;
        m_ovf = 1'b0;
        m_stall_held = 0;
        tick(6);
    endtask

    task automatic check_flags();
        check("tx_underrun", tx_underrun, m_und);
        check("rx_overflow", rx_overflow, m_ovf);
        check("frame_start_count", cnt_fs, exp_fs);
        check("frame_end_count", cnt_fe, exp_fe);
    endtask

    task automatic run_frame(input int nbytes, input int last_bits);
        logic [7:0] b;
        int nb;
        b = model_load();
        if (nbytes > 1 || last_bits == 8) q_miso.push_back(b);
        ss = 1'b0;
        exp_fs++;
        tick(8);
        for (int i = 0; i < nbytes; i++) begin
            nb = (i == nbytes - 1) ? last_bits : 8;
            for (int k = 0; k < nb; k++) begin
                si = mosi_b[i][7-k];
                if (k == 4 && sup_v[i]) offer_tx(sup_b[i]);
                if (k == 7) model_rx(mosi_b[i], i == 0);
                tick(4);
                sck = 1'b1;
                tick(4);
                sck = 1'b0;
            end
            if (nb == 8) begin
                b = model_load();
                if (i + 1 < nbytes && (i + 1 < nbytes - 1 || last_bits == 8))
                    q_miso.push_back(b);
            end
        end
        tick(4);
        ss = 1'b1;
        exp_fe++;
        tick(10);
    endtask

    task automatic clear_frame_arrays();
        for (int i = 0; i < 4; i++) begin
            mosi_b[i] = 8'h00;
            sup_v[i]  = 1'b0;
            sup_b[i]  = 8'h00;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        tick(1);
        apply_reset();

        // Single byte with a preloaded reply.
        clear_frame_arrays();
        offer_tx(8'hA5);
        mosi_b[0] = 8'h3C;
        run_frame(1, 8);
        check_flags();

        // Three bytes with replies supplied during each byte.
        apply_reset();
        clear_frame_arrays();
        offer_tx(8'h10);
        mosi_b[0] = 8'h01; mosi_b[1] = 8'h02; mosi_b[2] = 8'h03;
        sup_v[0] = 1'b1; sup_b[0] = 8'h20;
        sup_v[1] = 1'b1; sup_b[1] = 8'h30;
        sup_v[2] = 1'b1; sup_b[2] = 8'h40;
        run_frame(3, 8);
        check_flags();

        // Empty TX: fill bytes and underrun.
        clear_frame_arrays();
        mosi_b[0] = 8'($urandom); mosi_b[1] = 8'($urandom);
        run_frame(2, 8);
        check_flags();

        // Consumer stalled across two bytes.
        apply_reset();
        clear_frame_arrays();
        stalled = 1'b1;
        rx_ready = 1'b0;
        mosi_b[0] = 8'h11; mosi_b[1] = 8'h22;
        run_frame(2, 8);
        check("stall_rx_valid", rx_valid, 1);
        check("stall_rx_data", rx_data, 8'h11);
        check("stall_rx_first", rx_first, 1);
        check_flags();
        rx_ready = 1'b1;
        stalled = 1'b0;
        m_stall_held = 0;
        tick(3);
        check("stall_rx_valid_after_accept", rx_valid, 0);

        // Partial byte abandoned, then a fresh frame.
        apply_reset();
        clear_frame_arrays();
        mosi_b[0] = 8'($urandom);
        run_frame(1, 5);
        clear_frame_arrays();
        offer_tx(8'h96);
        mosi_b[0] = 8'h5A;
        run_frame(1, 8);
        check_flags();

        // Reset pulsed mid-byte while selected.
        apply_reset();
        mon_en = 1'b0;
        void'(model_load());
        ss = 1'b0;
        exp_fs++;
        tick(8);
        for (int k = 0; k < 3; k++) begin
            si = 1'($urandom);
            tick(4); sck = 1'b1; tick(4); sck = 1'b0;
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_hold_full = 1'b0;
        m_und = 1'b0;
        m_ovf = 1'b0;
        tick(2);
        check("midreset_so_oe", so_oe, 0);
        check("midreset_so", so, 1);
        for (int k = 0; k < 8; k++) begin
            si = 1'($urandom);
            tick(4); sck = 1'b1; tick(4); sck = 1'b0;
            check("midreset_so_oe_bit", so_oe, 0);
        end
        tick(4);
        ss = 1'b1;
        tick(10);
        check("midreset_rx_valid", rx_valid, 0);
        mon_en = 1'b1;
        clear_frame_arrays();
        offer_tx(8'hC3);
        mosi_b[0] = 8'h5A;
        run_frame(1, 8);
        check_flags();

        // Randomised frames.
        for (int f = 0; f < 6; f++) begin
            int n, last;
            n = $urandom_range(1, 3);
            last = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            for (int i = 0; i < 4; i++) begin
                mosi_b[i] = 8'($urandom);
                sup_v[i]  = 1'($urandom_range(0, 1));
                sup_b[i]  = 8'($urandom);
            end
            if (!m_hold_full && $urandom_range(0, 1) == 1) offer_tx(8'($urandom));
            run_frame(n, last);
            check_flags();
        end

        t = 0;
        while (q_rx.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        check("rx_queue_empty", q_rx.size(), 0);
        check("miso_queue_empty", q_miso.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
